// File: rtl/store_buffer_pkg.sv
// Shared widths, sizes and the commit feedback bundle for the store buffer.
package store_buffer_pkg;

   localparam int ADDR_WIDTH        = 32;
   localparam int SIZE_WIDTH        = 2;
   localparam int BUS_DATA_WIDTH    = 32;
   localparam int REG_DATA_WIDTH    = 32;
   localparam int ROB_ID_WIDTH      = 6;
   localparam int STORE_BUFFER_SIZE = 16;
   localparam int COMMIT_WIDTH      = 4;

   localparam int SB_PTR_W  = $clog2(STORE_BUFFER_SIZE);
   localparam int BUS_BYTES = BUS_DATA_WIDTH / 8;
   localparam int REG_BYTES = REG_DATA_WIDTH / 8;
   localparam int BYTE_OFS_W = $clog2(REG_BYTES);

   typedef struct packed {
      logic                                      enable;
      logic                                      next_handle_rob_id_valid;
      logic [ROB_ID_WIDTH-1:0]                   next_handle_rob_id;
      logic                                      has_exception;
      logic [ADDR_WIDTH-1:0]                     exception_pc;
      logic                                      flush;
      logic [COMMIT_WIDTH-1:0][ROB_ID_WIDTH-1:0] committed_rob_id;
      logic [COMMIT_WIDTH-1:0]                   committed_rob_id_valid;
      logic                                      jump_enable;
      logic                                      jump;
      logic [ADDR_WIDTH-1:0]                     next_pc;
   } commit_feedback_pack_t;

   // Number of bytes touched by an access of the given size code.
   function automatic logic [ADDR_WIDTH-1:0] size_bytes(input logic [SIZE_WIDTH-1:0] size);
      return ADDR_WIDTH'(1) << size;
   endfunction

endpackage

// File: rtl/store_buffer_forward.sv
// Store-to-load forwarding: per load byte, pick the youngest buffered store
// covering that address, else the raw bus byte. Purely combinational.
module store_buffer_forward
   import store_buffer_pkg::*;
(
   input  logic [STORE_BUFFER_SIZE-1:0]                     ent_valid,
   input  logic [STORE_BUFFER_SIZE-1:0][ADDR_WIDTH-1:0]     ent_addr,
   input  logic [STORE_BUFFER_SIZE-1:0][SIZE_WIDTH-1:0]     ent_size,
   input  logic [STORE_BUFFER_SIZE-1:0][REG_DATA_WIDTH-1:0] ent_data,
   input  logic [SB_PTR_W-1:0]                              head_idx,
   input  logic [ADDR_WIDTH-1:0]                            ld_addr,
   input  logic [REG_DATA_WIDTH-1:0]                        bus_data,
   output logic [BUS_DATA_WIDTH-1:0]                        feedback
);

   for (genvar k = 0; k < BUS_BYTES; k++) begin : g_byte
      logic [7:0] fb_byte;

      // Walk oldest to youngest so the youngest covering store wins.
      always_comb begin
         logic [SB_PTR_W-1:0]   e;
         logic [ADDR_WIDTH-1:0] ofs;
         fb_byte = bus_data[k*8 +: 8];
         for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
            e   = head_idx + SB_PTR_W'(i);
            ofs = ld_addr + ADDR_WIDTH'(k) - ent_addr[e];
            if (ent_valid[e] && (ofs < size_bytes(ent_size[e])) &&
                (ofs < ADDR_WIDTH'(REG_BYTES)))
               fb_byte = ent_data[e][{ofs[BYTE_OFS_W-1:0], 3'b000} +: 8];
         end
      end

      assign feedback[k*8 +: 8] = fb_byte;
   end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: holds speculative stores by ROB id, drains committed
// stores to the bus, drops uncommitted ones on flush, forwards to loads.
// Optional macro STORE_BUFFER_ASSERT_EN enables simulation-only assertions.
module store_buffer
   import store_buffer_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ADDR_WIDTH-1:0]     issue_stbuf_read_addr,
   input  logic [SIZE_WIDTH-1:0]     issue_stbuf_read_size,
   input  logic                      issue_stbuf_rd,
   output logic [BUS_DATA_WIDTH-1:0] stbuf_exlsu_bus_data,
   output logic [BUS_DATA_WIDTH-1:0] stbuf_exlsu_bus_data_feedback,
   output logic                      stbuf_exlsu_bus_ready,
   input  logic [ROB_ID_WIDTH-1:0]   exlsu_stbuf_rob_id,
   input  logic [ADDR_WIDTH-1:0]     exlsu_stbuf_write_addr,
   input  logic [SIZE_WIDTH-1:0]     exlsu_stbuf_write_size,
   input  logic [REG_DATA_WIDTH-1:0] exlsu_stbuf_write_data,
   input  logic                      exlsu_stbuf_push,
   output logic                      stbuf_exlsu_full,
   output logic                      stbuf_all_empty,
   output logic [ADDR_WIDTH-1:0]     stbuf_bus_read_addr,
   output logic [SIZE_WIDTH-1:0]     stbuf_bus_read_size,
   output logic                      stbuf_bus_read_req,
   input  logic [REG_DATA_WIDTH-1:0] bus_stbuf_data,
   input  logic                      bus_stbuf_read_ack,
   output logic [ADDR_WIDTH-1:0]     stbuf_bus_write_addr,
   output logic [SIZE_WIDTH-1:0]     stbuf_bus_write_size,
   output logic [REG_DATA_WIDTH-1:0] stbuf_bus_data,
   output logic                      stbuf_bus_write_req,
   input  logic                      bus_stbuf_write_ack,
   input  commit_feedback_pack_t     commit_feedback_pack
);

   localparam int N = STORE_BUFFER_SIZE;
   typedef logic [SB_PTR_W:0] ptr_t;

   logic [N-1:0]                     valid_q, valid_d;
   logic [N-1:0]                     committed_q, committed_d;
   logic [N-1:0][ROB_ID_WIDTH-1:0]   rob_id_q, rob_id_d;
   logic [N-1:0][ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [N-1:0][SIZE_WIDTH-1:0]     size_q, size_d;
   logic [N-1:0][REG_DATA_WIDTH-1:0] data_q, data_d;
   ptr_t                             head_q, head_d;
   ptr_t                             tail_q, tail_d;
   logic [ADDR_WIDTH-1:0]            ld_addr_q, ld_addr_d;
   logic [SIZE_WIDTH-1:0]            ld_size_q, ld_size_d;

   logic [SB_PTR_W-1:0] head_idx, tail_idx;
   ptr_t                count, keep_cnt;
   logic                full, flush_now, write_req, pop;
   logic [N-1:0]        commit_hit;

   assign head_idx  = head_q[SB_PTR_W-1:0];
   assign tail_idx  = tail_q[SB_PTR_W-1:0];
   assign count     = tail_q - head_q;
   assign full      = (count == ptr_t'(N));
   assign flush_now = commit_feedback_pack.enable & commit_feedback_pack.flush;
   assign write_req = valid_q[head_idx] & committed_q[head_idx] & ~flush_now;
   assign pop       = write_req & bus_stbuf_write_ack;

   // Load path passes straight through to/from the bus.
   assign stbuf_bus_read_addr   = issue_stbuf_read_addr;
   assign stbuf_bus_read_size   = issue_stbuf_read_size;
   assign stbuf_bus_read_req    = issue_stbuf_rd;
   assign stbuf_exlsu_bus_ready = bus_stbuf_read_ack;
   assign stbuf_exlsu_bus_data  = bus_stbuf_data;

   assign stbuf_exlsu_full     = full;
   assign stbuf_all_empty      = (count == '0);
   assign stbuf_bus_write_req  = write_req;
   assign stbuf_bus_write_addr = addr_q[head_idx];
   assign stbuf_bus_write_size = size_q[head_idx];
   assign stbuf_bus_data       = data_q[head_idx];

   // Fields of the commit bundle this block does not consume.
   logic unused_cfp;
   assign unused_cfp = ^{commit_feedback_pack.next_handle_rob_id_valid,
                         commit_feedback_pack.next_handle_rob_id,
                         commit_feedback_pack.has_exception,
                         commit_feedback_pack.exception_pc,
                         commit_feedback_pack.jump_enable,
                         commit_feedback_pack.jump,
                         commit_feedback_pack.next_pc,
                         ld_size_q};

   // Entries whose ROB id matches any valid commit slot this cycle.
   always_comb begin
      commit_hit = '0;
      for (int e = 0; e < N; e++)
         for (int j = 0; j < COMMIT_WIDTH; j++)
            if (commit_feedback_pack.enable && valid_q[e] &&
                commit_feedback_pack.committed_rob_id_valid[j] &&
                (rob_id_q[e] == commit_feedback_pack.committed_rob_id[j]))
               commit_hit[e] = 1'b1;
   end

   // Next-state of the queue: commit, then flush or push, then pop.
   always_comb begin
      valid_d     = valid_q;
      committed_d = committed_q | commit_hit;
      rob_id_d    = rob_id_q;
      addr_d      = addr_q;
      size_d      = size_q;
      data_d      = data_q;
      head_d      = head_q;
      tail_d      = tail_q;
      keep_cnt    = '0;
      if (flush_now) begin
         // Survivors are exactly the committed entries, contiguous from head;
         // a push in this cycle is dropped.
         for (int e = 0; e < N; e++) begin
            valid_d[e] = valid_q[e] & committed_d[e];
            if (valid_d[e]) keep_cnt = keep_cnt + ptr_t'(1);
         end
         tail_d = head_q + keep_cnt;
      end else if (exlsu_stbuf_push && !full) begin
         valid_d[tail_idx]     = 1'b1;
         committed_d[tail_idx] = 1'b0;
         rob_id_d[tail_idx]    = exlsu_stbuf_rob_id;
         addr_d[tail_idx]      = exlsu_stbuf_write_addr;
         size_d[tail_idx]      = exlsu_stbuf_write_size;
         data_d[tail_idx]      = exlsu_stbuf_write_data;
         tail_d                = tail_q + ptr_t'(1);
      end
      // Pop is gated off during flush, so it never fights the tail rewind.
      if (pop) begin
         valid_d[head_idx]     = 1'b0;
         committed_d[head_idx] = 1'b0;
         head_d                = head_q + ptr_t'(1);
      end
   end

   // Load address/size captured for forwarding while a read is issued.
   always_comb begin
      ld_addr_d = issue_stbuf_rd ? issue_stbuf_read_addr : ld_addr_q;
      ld_size_d = issue_stbuf_rd ? issue_stbuf_read_size : ld_size_q;
   end

   // State registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q     <= '0;
         committed_q <= '0;
         rob_id_q    <= '0;
         addr_q      <= '0;
         size_q      <= '0;
         data_q      <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         ld_addr_q   <= '0;
         ld_size_q   <= '0;
      end else begin
         valid_q     <= valid_d;
         committed_q <= committed_d;
         rob_id_q    <= rob_id_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         data_q      <= data_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         ld_addr_q   <= ld_addr_d;
         ld_size_q   <= ld_size_d;
      end
   end

   store_buffer_forward u_forward (
      .ent_valid (valid_q),
      .ent_addr  (addr_q),
      .ent_size  (size_q),
      .ent_data  (data_q),
      .head_idx  (head_idx),
      .ld_addr   (ld_addr_q),
      .bus_data  (bus_stbuf_data),
      .feedback  (stbuf_exlsu_bus_data_feedback)
   );

`ifdef STORE_BUFFER_ASSERT_EN
   // Sticky flag: a read has been issued at some point since reset.
   logic rd_seen_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rd_seen_q <= 1'b0;
      else      rd_seen_q <= rd_seen_q | issue_stbuf_rd;
   end

   a_push_full: assert property (@(posedge clk) disable iff (!rst)
      !(exlsu_stbuf_push && full));
   a_wack_noreq: assert property (@(posedge clk) disable iff (!rst)
      !(bus_stbuf_write_ack && !write_req));
   a_rack_noreq: assert property (@(posedge clk) disable iff (!rst)
      !(bus_stbuf_read_ack && !rd_seen_q && !issue_stbuf_rd));

   // No two live entries may share a ROB id.
   always @(posedge clk) begin
      if (rst)
         for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++)
               a_dup_rob: assert (!(valid_q[i] && valid_q[j] && rob_id_q[i] == rob_id_q[j]));
   end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: pass-through read path, forwarding merge,
// fill/full, in-order drain and flush behaviour.
module tb_store_buffer;
   import store_buffer_pkg::*;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [ADDR_WIDTH-1:0]     rd_addr;
   logic [SIZE_WIDTH-1:0]     rd_size;
   logic                      rd;
   logic [BUS_DATA_WIDTH-1:0] bus_data_o, feedback;
   logic                      bus_ready;
   logic [ROB_ID_WIDTH-1:0]   st_rob;
   logic [ADDR_WIDTH-1:0]     st_addr;
   logic [SIZE_WIDTH-1:0]     st_size;
   logic [REG_DATA_WIDTH-1:0] st_data;
   logic                      push;
   logic                      full, all_empty;
   logic [ADDR_WIDTH-1:0]     br_addr;
   logic [SIZE_WIDTH-1:0]     br_size;
   logic                      br_req;
   logic [REG_DATA_WIDTH-1:0] bus_rdata;
   logic                      rack;
   logic [ADDR_WIDTH-1:0]     bw_addr;
   logic [SIZE_WIDTH-1:0]     bw_size;
   logic [REG_DATA_WIDTH-1:0] bw_data;
   logic                      bw_req;
   logic                      wack;
   commit_feedback_pack_t     cfp;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   store_buffer dut (
      .clk                           (clk),
      .rst                           (rst),
      .issue_stbuf_read_addr         (rd_addr),
      .issue_stbuf_read_size         (rd_size),
      .issue_stbuf_rd                (rd),
      .stbuf_exlsu_bus_data          (bus_data_o),
      .stbuf_exlsu_bus_data_feedback (feedback),
      .stbuf_exlsu_bus_ready         (bus_ready),
      .exlsu_stbuf_rob_id            (st_rob),
      .exlsu_stbuf_write_addr        (st_addr),
      .exlsu_stbuf_write_size        (st_size),
      .exlsu_stbuf_write_data        (st_data),
      .exlsu_stbuf_push              (push),
      .stbuf_exlsu_full              (full),
      .stbuf_all_empty               (all_empty),
      .stbuf_bus_read_addr           (br_addr),
      .stbuf_bus_read_size           (br_size),
      .stbuf_bus_read_req            (br_req),
      .bus_stbuf_data                (bus_rdata),
      .bus_stbuf_read_ack            (rack),
      .stbuf_bus_write_addr          (bw_addr),
      .stbuf_bus_write_size          (bw_size),
      .stbuf_bus_data                (bw_data),
      .stbuf_bus_write_req           (bw_req),
      .bus_stbuf_write_ack           (wack),
      .commit_feedback_pack          (cfp)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_dut();
      @(posedge clk);
      #1;
      push = 0; rd = 0; rack = 0; wack = 0; cfp = '0;
      rst = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   task automatic do_push(input int rob, input int addr, input int size, input logic [31:0] data);
      st_rob  = ROB_ID_WIDTH'(rob);
      st_addr = ADDR_WIDTH'(addr);
      st_size = SIZE_WIDTH'(size);
      st_data = data;
      push    = 1'b1;
      step();
      push    = 1'b0;
   endtask

   task automatic do_read(input int addr);
      rd_addr = ADDR_WIDTH'(addr);
      rd_size = 2'd2;
      rd      = 1'b1;
      step();
      rd      = 1'b0;
      bus_rdata = 32'hdeadbeef;
      #1;
   endtask

   task automatic fwd_case(input string tag, input int saddr, input int ssize,
                           input int raddr, input logic [31:0] exp);
      rst_dut();
      do_push(1, saddr, ssize, 32'haabbccdd);
      do_read(raddr);
      chk(tag, feedback, exp);
   endtask

   initial begin
      rst = 1'b0;
      rd = 1'b1; rd_addr = '0; rd_size = '0;
      push = 0; st_rob = '0; st_addr = '0; st_size = '0; st_data = '0;
      bus_rdata = '0; rack = 0; wack = 0; cfp = '0;

      // Reset-state outputs.
      #3;
      chk("rst_full", full, 0);
      chk("rst_empty", all_empty, 1);
      chk("rst_wreq", bw_req, 0);
      chk("rst_rreq", br_req, 1);
      #10;
      rst = 1'b1;
      rd = 1'b0;

      // Read pass-through and raw return data.
      rd_addr = 32'h1524abe0; rd_size = 2'd1; rd = 1'b1;
      #1;
      chk("rd_addr", br_addr, 32'h1524abe0);
      chk("rd_size", br_size, 1);
      chk("rd_req", br_req, 1);
      step();
      rd = 1'b0; rack = 1'b1; bus_rdata = 32'hdeadbeef;
      #1;
      chk("rd_ready", bus_ready, 1);
      chk("rd_data", bus_data_o, 32'hdeadbeef);
      chk("rd_fb", feedback, 32'hdeadbeef);
      rack = 1'b0;

      // Forwarding merges over bus data 0xdeadbeef.
      fwd_case("fwd_w0_r0", 0, 2, 0, 32'haabbccdd);
      fwd_case("fwd_w2_r0", 2, 2, 0, 32'hccddbeef);
      fwd_case("fwd_w0_r2", 0, 2, 2, 32'hdeadaabb);
      fwd_case("fwd_h0_r0", 0, 1, 0, 32'hdeadccdd);

      rst_dut();
      do_push(1, 0, 1, 32'h0000ffee);
      do_push(2, 3, 0, 32'h0000003f);
      do_push(3, 4, 2, 32'hddccbbaa);
      do_read(1);
      chk("fwd_youngest", feedback, 32'haa3fbeff);

      // Fill to full, extra push ignored, commit and drain in order.
      rst_dut();
      for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
         do_push(i, i, 2, 32'h1581abcf + 32'(i));
         if (i == 0) chk("fill_nonempty", all_empty, 0);
         if (i == STORE_BUFFER_SIZE - 2) chk("fill_notfull", full, 0);
      end
      chk("fill_full", full, 1);
      do_push(40, 32'h80, 2, 32'h12345678);
      chk("fill_extra_full", full, 1);
      chk("fill_no_drain_yet", bw_req, 0);
      for (int c = 0; c < STORE_BUFFER_SIZE / COMMIT_WIDTH; c++) begin
         cfp.enable = 1'b1;
         for (int j = 0; j < COMMIT_WIDTH; j++) begin
            cfp.committed_rob_id[j]       = ROB_ID_WIDTH'(c * COMMIT_WIDTH + j);
            cfp.committed_rob_id_valid[j] = 1'b1;
         end
         step();
      end
      cfp = '0;
      #1;
      for (int i = 0; i < STORE_BUFFER_SIZE; i++) begin
         chk($sformatf("drain%0d_req", i), bw_req, 1);
         chk($sformatf("drain%0d_addr", i), bw_addr, i);
         chk($sformatf("drain%0d_data", i), bw_data, 32'h1581abcf + 32'(i));
         step();
         chk($sformatf("drain%0d_hold_req", i), bw_req, 1);
         chk($sformatf("drain%0d_hold_addr", i), bw_addr, i);
         wack = 1'b1;
         step();
         wack = 1'b0;
      end
      #1;
      chk("drain_empty", all_empty, 1);
      chk("drain_req_off", bw_req, 0);

      // Flush drops an uncommitted store; a push in the flush cycle is dropped.
      rst_dut();
      do_push(1, 32'h10, 2, 32'h11111111);
      cfp.enable = 1'b1; cfp.flush = 1'b1;
      st_rob = 6'd2; st_addr = 32'h20; st_data = 32'h22222222; push = 1'b1;
      step();
      push = 1'b0; cfp = '0;
      #1;
      chk("flush_empty", all_empty, 1);
      chk("flush_wreq", bw_req, 0);

      // Commit and flush together keep the entry; drain waits for flush to drop.
      rst_dut();
      do_push(1, 32'h100, 2, 32'h55aa55aa);
      cfp.enable = 1'b1; cfp.flush = 1'b1;
      cfp.committed_rob_id[0] = 6'd1; cfp.committed_rob_id_valid[0] = 1'b1;
      #1;
      chk("cf_wreq_c0", bw_req, 0);
      step();
      cfp.committed_rob_id_valid[0] = 1'b0;
      #1;
      chk("cf_wreq_flush", bw_req, 0);
      chk("cf_kept", all_empty, 0);
      step();
      cfp = '0;
      #1;
      chk("cf_kept2", all_empty, 0);
      chk("cf_wreq", bw_req, 1);
      chk("cf_waddr", bw_addr, 32'h100);
      chk("cf_wdata", bw_data, 32'h55aa55aa);
      wack = 1'b1;
      step();
      wack = 1'b0;
      #1;
      chk("cf_empty", all_empty, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- In-order store queue between the LSU execute stage (exlsu) and the memory bus, holding speculative stores tagged by ROB id.
- Stores drain to the bus only after commit and are discarded on a pipeline flush.
- Load reads are issued straight to the bus. Returned data is merged byte-wise with younger buffered stores (store-to-load forwarding) before it reaches exlsu.

Parameters:
- ADDR_WIDTH, 32, address width.
- SIZE_WIDTH, 2, access size code: 0=byte, 1=half, 2=word; byte count = 1<<size.
- BUS_DATA_WIDTH, 32, load data width.
- REG_DATA_WIDTH, 32, store data width.
- ROB_ID_WIDTH, 6, ROB tag width.
- STORE_BUFFER_SIZE, 16, entry count; must be a power of 2 and a multiple of COMMIT_WIDTH.
- COMMIT_WIDTH, 4, commit slots per cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- issue_stbuf_read_addr  in  ADDR_WIDTH  load address.
- issue_stbuf_read_size  in  SIZE_WIDTH  load size.
- issue_stbuf_rd  in  1  load request.
- stbuf_exlsu_bus_data  out  BUS_DATA_WIDTH  raw bus load data.
- stbuf_exlsu_bus_data_feedback  out  BUS_DATA_WIDTH  load data after forwarding.
- stbuf_exlsu_bus_ready  out  1  load data valid.
- exlsu_stbuf_rob_id  in  ROB_ID_WIDTH  store tag.
- exlsu_stbuf_write_addr  in  ADDR_WIDTH  store address.
- exlsu_stbuf_write_size  in  SIZE_WIDTH  store size.
- exlsu_stbuf_write_data  in  REG_DATA_WIDTH  store data, right-aligned.
- exlsu_stbuf_push  in  1  enqueue store.
- stbuf_exlsu_full  out  1  no free entry.
- stbuf_all_empty  out  1  no valid entry.
- stbuf_bus_read_addr  out  ADDR_WIDTH  bus read address.
- stbuf_bus_read_size  out  SIZE_WIDTH  bus read size.
- stbuf_bus_read_req  out  1  bus read request.
- bus_stbuf_data  in  REG_DATA_WIDTH  bus read data.
- bus_stbuf_read_ack  in  1  bus read done.
- stbuf_bus_write_addr  out  ADDR_WIDTH  bus write address.
- stbuf_bus_write_size  out  SIZE_WIDTH  bus write size.
- stbuf_bus_data  out  REG_DATA_WIDTH  bus write data.
- stbuf_bus_write_req  out  1  bus write request.
- bus_stbuf_write_ack  in  1  bus write done.
- commit_feedback_pack  in  commit_feedback_pack_t  commit info; only enable, flush, committed_rob_id[], committed_rob_id_valid[] are used.

Behaviour:
- Storage: circular FIFO of STORE_BUFFER_SIZE entries {valid, committed, rob_id, addr, size, data}. Head/tail pointers carry one extra wrap bit.
- Reset: all entries invalid, pointers 0, latched load addr/size 0.
  - Output values held during reset: full=0, all_empty=1, write_req=0, read_req=issue_stbuf_rd.
- Read path (combinational pass-through): stbuf_bus_read_addr/size/req = issue_stbuf_read_addr/size/rd.
  - stbuf_exlsu_bus_ready = bus_stbuf_read_ack; stbuf_exlsu_bus_data = bus_stbuf_data.
- Forwarding:
  - Load addr/size are registered on each clk edge while issue_stbuf_rd=1.
  - feedback byte k (k < BUS_DATA_WIDTH/8) covers address latched_addr+k.
  - That byte is taken from the youngest valid entry covering the address (entry byte = addr - entry.addr, with 0 <= entry byte < 1<<entry.size). If no entry covers it, the byte comes from bus_stbuf_data byte k.
  - Purely combinational from entries and bus data. Committed and uncommitted entries both forward.
- Push: on exlsu_stbuf_push & !full, the entry at tail is written (committed=0) and tail advances. A push while full is ignored.
- full = count==STORE_BUFFER_SIZE; all_empty = count==0.
- Commit: when commit_feedback_pack.enable, every valid entry whose rob_id equals any committed_rob_id[j] with valid[j] set gets committed=1 at the edge.
- Flush: when enable & flush, every valid entry that is neither committed nor committed in this same cycle is invalidated.
  - Tail moves back to just past the youngest surviving entry; this is equivalent to head+committed count, since committed entries are contiguous from head.
- Drain:
  - stbuf_bus_write_req = head.valid & head.committed & !(enable & flush).
  - write addr/size/data come from the head entry.
  - Request and fields stay stable until bus_stbuf_write_ack. On ack & req, head is invalidated and advances.
- Simultaneous push, commit, flush and pop in one cycle all take effect. A push in a flush cycle is discarded.

Optional Feature:
- STORE_BUFFER_ASSERT_EN: when defined, simulation-only assertions fire on:
  - push while full;
  - write ack without write_req;
  - read ack without a prior read request;
  - any two valid entries carrying the same rob_id.
- When undefined, no assertion code is compiled; RTL behaviour is identical either way.

Decomposition:
- Shared package/headers hold the width/size constants listed above and commit_feedback_pack_t:
  - enable, next_handle_rob_id_valid, next_handle_rob_id, has_exception, exception_pc, flush;
  - committed_rob_id[COMMIT_WIDTH], committed_rob_id_valid[COMMIT_WIDTH];
  - jump_enable, jump, next_pc.
- One natural sub-module: store_buffer_forward, the combinational byte-merge network.

Test Plan:
- Read 0x1524abe0 size 1 -> bus read req/addr/size mirror the inputs.
  - Then read_ack with data 0xdeadbeef -> bus_ready=1; data=feedback=0xdeadbeef.
- Bus data 0xdeadbeef, each case from an empty buffer with a word read, expected feedback:
  - store 0xaabbccdd word @0, read @0 -> 0xaabbccdd;
  - same store @2, read @0 -> 0xccddbeef;
  - store @0, read @2 -> 0xdeadaabb;
  - half-store @0, read @0 -> 0xdeadccdd.
- Stores 0xffee half @0, 0x3f byte @3, 0xddccbbaa word @4; word read @1 -> feedback 0xaa3fbeff (youngest-wins ordering).
- Push STORE_BUFFER_SIZE entries -> all_empty=0 after the first push, full=1 after the last; an extra push is ignored.
- Fill with rob_id i, addr i, data 0x1581abcf+i; commit COMMIT_WIDTH ids per cycle.
  - Each head drains in order with write_req held through a no-ack cycle, popping on ack; all_empty=1 at the end.
- Flush cases:
  - Push rob 1, then flush -> all_empty=1.
  - Push rob 1, then commit rob 1 and flush in the same cycle -> entry kept, write_req=0 while flush is high, write_req=1 once flush drops; ack -> all_empty=1.
